// File: rtl/plab3_mem_secure_mem_guard.sv
// Security guard between the blocking L2 cache and main memory: forwards requests the
// requesting domain may make, and answers forbidden ones locally with zero data and insecure.
//
// state | meaning
// IDLE  | ready for a new L2 request
// CHECK | evaluate the latched request against the region/domain policy
// FWD   | present the latched request to memory
// WAIT  | wait for the memory response
// RESP  | return the latched memory response to L2
// DENY  | return a zero-data denial to L2 with insecure asserted
module plab3_mem_secure_mem_guard #(
   parameter int          p_opaque_nbits = 8,
   parameter int          abw            = 32,
   parameter int          clw            = 128,
   parameter logic [31:0] p_split_addr   = 32'h00010000,
   localparam int         lw             = $clog2(clw/8),
   localparam int         req_nbits      = 3 + p_opaque_nbits + abw + lw + clw,
   localparam int         resp_nbits     = 3 + p_opaque_nbits + lw + clw
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  domain,
   input  logic [req_nbits-1:0]  l2req_msg,
   input  logic                  l2req_val,
   output logic                  l2req_rdy,
   output logic [resp_nbits-1:0] l2resp_msg,
   output logic                  l2resp_val,
   input  logic                  l2resp_rdy,
   output logic                  insecure,
   output logic [req_nbits-1:0]  memreq_msg,
   output logic                  memreq_val,
   input  logic                  memreq_rdy,
   input  logic [resp_nbits-1:0] memresp_msg,
   input  logic                  memresp_val,
   output logic                  memresp_rdy,
   output logic [7:0]            deny_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_FWD,
      ST_WAIT,
      ST_RESP,
      ST_DENY
   } state_t;

   state_t                  state_q, state_d;
   logic [req_nbits-1:0]    req_q, req_d;
   logic                    dom_q, dom_d;
   logic [resp_nbits-1:0]   resp_q, resp_d;
   logic [7:0]              deny_count_q, deny_count_d;

   logic [2:0]                req_type;
   logic [p_opaque_nbits-1:0] req_opaque;
   logic [abw-1:0]            req_addr;
   logic                      in_l_region;
   logic                      deny;

   assign req_type    = req_q[clw+lw+abw+p_opaque_nbits +: 3];
   assign req_opaque  = req_q[clw+lw+abw +: p_opaque_nbits];
   assign req_addr    = req_q[clw+lw +: abw];
   assign in_l_region = (req_addr < abw'(p_split_addr));

   // L domain may not touch H at all; H domain may read anywhere but never write down into L.
   assign deny = dom_q ? (in_l_region && (req_type != 3'd0)) : !in_l_region;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         dom_q        <= 1'b0;
         resp_q       <= '0;
         deny_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         dom_q        <= dom_d;
         resp_q       <= resp_d;
         deny_count_q <= deny_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      dom_d        = dom_q;
      resp_d       = resp_q;
      deny_count_d = deny_count_q;
      l2req_rdy    = 1'b0;
      l2resp_val   = 1'b0;
      l2resp_msg   = '0;
      insecure     = 1'b0;
      memreq_val   = 1'b0;
      memresp_rdy  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            l2req_rdy = 1'b1;
            if (l2req_val) begin
               req_d   = l2req_msg;
               dom_d   = domain;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = deny ? ST_DENY : ST_FWD;
         end
         ST_FWD: begin
            memreq_val = 1'b1;
            if (memreq_rdy) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            memresp_rdy = 1'b1;
            if (memresp_val) begin
               resp_d  = memresp_msg;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            l2resp_val = 1'b1;
            l2resp_msg = resp_q;
            if (l2resp_rdy) state_d = ST_IDLE;
         end
         ST_DENY: begin
            l2resp_val = 1'b1;
            insecure   = 1'b1;
            l2resp_msg = {req_type, req_opaque, {lw{1'b0}}, {clw{1'b0}}};
            if (l2resp_rdy) begin
               if (deny_count_q != 8'hFF) deny_count_d = deny_count_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign memreq_msg = req_q;
   assign deny_count = deny_count_q;

endmodule

// File: tb/tb_plab3_mem_secure_mem_guard.sv
// Scoreboard bench for the secure memory guard: expected memory requests and L2 responses
// are queued when a request is issued and compared when the guard hands them over.
module tb_plab3_mem_secure_mem_guard;

   localparam int          REQW  = 175;
   localparam int          RESPW = 143;
   localparam logic [31:0] SPLIT = 32'h00010000;

   logic             clk = 1'b0;
   logic             reset;
   logic             domain;
   logic [REQW-1:0]  l2req_msg;
   logic             l2req_val;
   logic             l2req_rdy;
   logic [RESPW-1:0] l2resp_msg;
   logic             l2resp_val;
   logic             l2resp_rdy;
   logic             insecure;
   logic [REQW-1:0]  memreq_msg;
   logic             memreq_val;
   logic             memreq_rdy;
   logic [RESPW-1:0] memresp_msg;
   logic             memresp_val;
   logic             memresp_rdy;
   logic [7:0]       deny_count;

   always #5 clk = ~clk;

   plab3_mem_secure_mem_guard dut (
      .clk         (clk),
      .reset       (reset),
      .domain      (domain),
      .l2req_msg   (l2req_msg),
      .l2req_val   (l2req_val),
      .l2req_rdy   (l2req_rdy),
      .l2resp_msg  (l2resp_msg),
      .l2resp_val  (l2resp_val),
      .l2resp_rdy  (l2resp_rdy),
      .insecure    (insecure),
      .memreq_msg  (memreq_msg),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memresp_msg (memresp_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .deny_count  (deny_count)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_resp = 0;
   int mv_cnt = 0;
   int fire_cyc, out_cyc, mf_cyc, rv_cyc;
   int dc_model = 0;
   logic             mem_hold = 1'b0;
   logic [127:0]     mem_data = '0;
   logic [REQW-1:0]  exp_mq[$];
   logic [RESPW:0]   exp_rq[$];
   logic [RESPW-1:0] memq[$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REQW-1:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                              input logic [31:0] a, input logic [127:0] d);
      return {t, o, a, 4'd0, d};
   endfunction

   function automatic logic [RESPW-1:0] mem_resp(input logic [REQW-1:0] r, input logic [127:0] md);
      logic [2:0] t;
      t = r[174:172];
      return {t, r[171:164], 4'd0, (t == 3'd0) ? md : 128'd0};
   endfunction

   function automatic logic model_deny(input logic dom, input logic [2:0] t, input logic [31:0] a);
      if (dom) return (a < SPLIT) && (t != 3'd0);
      return a >= SPLIT;
   endfunction

   // One clock: observe handshakes at the falling edge, then drive after the rising edge.
   task automatic tick();
      logic req_fire, mem_fire;
      @(negedge clk);
      req_fire = l2req_val && l2req_rdy;
      if (req_fire) fire_cyc = cyc;
      if ((memreq_val || l2resp_val) && out_cyc < 0 && fire_cyc >= 0) out_cyc = cyc;
      if (l2resp_val && rv_cyc < 0) rv_cyc = cyc;
      if (memreq_val) mv_cnt++;
      if (memreq_val && memreq_rdy) begin
         chk("memreq_expected", exp_mq.size() != 0, 1);
         if (exp_mq.size() != 0) chk("memreq_msg", memreq_msg, exp_mq.pop_front());
         memq.push_back(mem_resp(memreq_msg, mem_data));
      end
      mem_fire = memresp_val && memresp_rdy;
      if (mem_fire) mf_cyc = cyc;
      if (l2resp_val && l2resp_rdy) begin
         chk("l2resp_expected", exp_rq.size() != 0, 1);
         if (exp_rq.size() != 0) chk("l2resp", {insecure, l2resp_msg}, exp_rq.pop_front());
         n_resp++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (req_fire) begin
         l2req_val = 1'b0;
         domain    = ~domain;
         l2req_msg = ~l2req_msg;
      end
      if (mem_fire) begin
         memq.delete(0);
         memresp_val = 1'b0;
      end
      if (!memresp_val && memq.size() != 0 && !mem_hold) begin
         memresp_val = 1'b1;
         memresp_msg = memq[0];
      end
   endtask

   task automatic xact(input logic dom, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [127:0] md, input int mstall, input int rstall);
      logic [7:0]      opq;
      logic [REQW-1:0] msg;
      logic [RESPW:0]  er;
      logic            dn;
      int start, mv0, ms, rs;
      opq      = 8'($urandom);
      msg      = mk_req(typ, opq, addr, {$urandom, $urandom, $urandom, $urandom});
      mem_data = md;
      dn       = model_deny(dom, typ, addr);
      if (dn) er = {1'b1, typ, opq, 4'd0, 128'd0};
      else begin
         er = {1'b0, mem_resp(msg, md)};
         exp_mq.push_back(msg);
      end
      exp_rq.push_back(er);
      if (mstall > 0) memreq_rdy = 1'b0;
      if (rstall > 0) l2resp_rdy = 1'b0;
      domain = dom; l2req_msg = msg; l2req_val = 1'b1;
      start = n_resp; mv0 = mv_cnt; ms = 0; rs = 0;
      fire_cyc = -1; out_cyc = -1; mf_cyc = -1; rv_cyc = -1;
      for (int i = 0; i < 60 && n_resp == start; i++) begin
         tick();
         if (fire_cyc >= 0 && n_resp == start) chk("l2req_rdy_busy", l2req_rdy, 0);
         if (memreq_val && !memreq_rdy) begin
            chk("memreq_hold", memreq_msg, msg);
            ms++;
            if (ms >= mstall) memreq_rdy = 1'b1;
         end
         if (l2resp_val && !l2resp_rdy) begin
            chk("l2resp_hold", {insecure, l2resp_msg}, er);
            rs++;
            if (rs >= rstall) l2resp_rdy = 1'b1;
         end
      end
      chk("resp_count", n_resp - start, 1);
      chk("req_latency", out_cyc - fire_cyc, 2);
      if (dn) begin
         chk("no_memreq", mv_cnt - mv0, 0);
         if (dc_model < 255) dc_model++;
      end else begin
         chk("resp_latency", rv_cyc - mf_cyc, 1);
      end
      chk("deny_count", deny_count, dc_model);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_l2req_rdy"}, l2req_rdy, 1);
      chk({tag, "_memreq_val"}, memreq_val, 0);
      chk({tag, "_l2resp_val"}, l2resp_val, 0);
      chk({tag, "_memresp_rdy"}, memresp_rdy, 0);
      chk({tag, "_insecure"}, insecure, 0);
      chk({tag, "_l2resp_msg"}, l2resp_msg, 0);
      chk({tag, "_deny_count"}, deny_count, 0);
   endtask

   initial begin
      logic [REQW-1:0] m6;
      int r0;
      reset = 1'b1; domain = 1'b0; l2req_msg = '0; l2req_val = 1'b0;
      l2resp_rdy = 1'b1; memreq_rdy = 1'b1; memresp_msg = '0; memresp_val = 1'b0;
      fire_cyc = -1; out_cyc = -1; mf_cyc = -1; rv_cyc = -1;
      repeat (3) tick();
      chk_idle("reset");
      reset = 1'b0;
      tick();

      xact(1'b0, 3'd0, 32'h0000_0100, {16{8'hA5}}, 0, 0);
      xact(1'b0, 3'd0, 32'h0001_0000, {16{8'h3C}}, 0, 0);
      xact(1'b1, 3'd1, 32'h0000_FFF0, {16{8'h11}}, 0, 0);
      xact(1'b1, 3'd1, 32'h0001_0000, {16{8'h22}}, 0, 0);
      xact(1'b1, 3'd0, 32'h0000_0000, {16{8'h33}}, 0, 0);
      xact(1'b0, 3'd0, 32'h0000_FFFF, {16{8'h44}}, 0, 0);
      xact(1'b0, 3'd1, 32'h0000_FFFF, {16{8'h55}}, 0, 0);
      xact(1'b1, 3'd1, 32'h0000_FFFF, {16{8'h66}}, 0, 0);
      xact(1'b0, 3'd1, 32'hFFFF_FFFF, {16{8'h77}}, 0, 0);
      xact(1'b1, 3'd0, 32'hFFFF_FFF0, {16{8'h88}}, 0, 0);

      xact(1'b0, 3'd0, 32'h0000_0200, {16{8'h5A}}, 5, 3);
      r0 = n_resp;
      repeat (3) tick();
      chk("one_resp_after_stall", n_resp - r0, 0);

      for (int i = 0; i < 260; i++)
         xact(1'b0, 3'd0, 32'h0001_0000 + 32'(i * 16), 128'd0, 0, 0);
      chk("deny_sat", deny_count, 8'hFF);

      // Reset while a memory response is being offered in WAIT.
      mem_hold = 1'b1;
      m6 = mk_req(3'd0, 8'h6E, 32'h0000_0400, 128'd0);
      mem_data = {16{8'hEE}};
      exp_mq.push_back(m6);
      domain = 1'b0; l2req_msg = m6; l2req_val = 1'b1;
      for (int i = 0; i < 20 && memq.size() == 0; i++) tick();
      chk("wait_reached", memq.size(), 1);
      chk("wait_memresp_rdy", memresp_rdy, 1);
      memresp_val = 1'b1;
      memresp_msg = memq[0];
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_hold = 1'b0;
      dc_model = 0;
      chk_idle("post_reset");
      r0 = n_resp;
      repeat (4) tick();
      chk("no_stray_resp", n_resp - r0, 0);
      memq.delete();
      xact(1'b1, 3'd0, 32'h0000_0800, {16{8'h9C}}, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
